// File: rtl/stim_pattern_driver.sv
// Stimulus pattern driver: walks an LFSR through NUM_PATTERNS stimulus
// vectors and holds each one for SETTLE_CYCLES+1 cycles. It then folds the
// subcircuit response bit into a MISR, and the final MISR value is the run
// signature.
//
// Handshake: start and seed_load are single-cycle requests sampled on the
// rising clock edge. They are acted on only while the FSM is idle (IDLE or
// DONE) and are silently dropped while busy=1. If both arrive in the same
// cycle, the seed is loaded first and the new run uses the new seed.
// dut_resp is sampled only on the edge that ends a CAPTURE cycle.
// dbg_state_o exposes the raw FSM state for external checkers.
module stim_pattern_driver #(
    parameter int          NUM_PATTERNS  = 256,
    parameter int          SETTLE_CYCLES = 2,
    parameter logic [15:0] SEED          = 16'hACE1
) (
    input  logic        I1470_clk,
    input  logic        I1477_rst,
    input  logic        start,
    input  logic        seed_load,
    input  logic [15:0] seed_in,
    input  logic        dut_resp,
    output logic [4:0]  stim_out,
    output logic        stim_valid,
    output logic        busy,
    output logic        done,
    output logic [15:0] signature,
    output logic [2:0]  dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DRIVE   = 3'd1,
        S_SETTLE  = 3'd2,
        S_CAPTURE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [15:0] LAST_PAT    = 16'(NUM_PATTERNS - 1);
    localparam logic [3:0]  SETTLE_INIT = 4'(SETTLE_CYCLES - 1);
    // An all-zero LFSR would never leave zero, so zero seeds become 1.
    localparam logic [15:0] RESET_LFSR  = (SEED == 16'h0000) ? 16'h0001 : SEED;

    state_t      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [15:0] misr_q, misr_d;
    logic [15:0] pat_cnt_q, pat_cnt_d;
    logic [3:0]  settle_cnt_q, settle_cnt_d;
    logic [4:0]  stim_out_q, stim_out_d;
    logic        stim_valid_q, stim_valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        lfsr_fb;
    logic        misr_fb;

    assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    assign misr_fb = misr_q[0] ^ misr_q[2] ^ misr_q[3] ^ misr_q[5];

    // Next-state logic for the FSM, counters, LFSR and MISR.
    always_comb begin
        state_d      = state_q;
        lfsr_d       = lfsr_q;
        misr_d       = misr_q;
        pat_cnt_d    = pat_cnt_q;
        settle_cnt_d = settle_cnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (seed_load) begin
                    lfsr_d = (seed_in == 16'h0000) ? 16'h0001 : seed_in;
                end
                if (start) begin
                    state_d   = S_DRIVE;
                    pat_cnt_d = 16'h0000;
                    misr_d    = 16'h0000;
                end
            end
            S_DRIVE: begin
                state_d      = S_SETTLE;
                settle_cnt_d = SETTLE_INIT;
            end
            S_SETTLE: begin
                if (settle_cnt_q == 4'd0) begin
                    state_d = S_CAPTURE;
                end else begin
                    settle_cnt_d = settle_cnt_q - 4'd1;
                end
            end
            S_CAPTURE: begin
                misr_d    = {misr_fb ^ dut_resp, misr_q[15:1]};
                lfsr_d    = {lfsr_fb, lfsr_q[15:1]};
                pat_cnt_d = pat_cnt_q + 16'd1;
                state_d   = (pat_cnt_q == LAST_PAT) ? S_DONE : S_DRIVE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output values for the next cycle, derived from the next state so the
    // outputs can be registered without adding a cycle of latency.
    always_comb begin
        stim_valid_d = (state_d == S_DRIVE) || (state_d == S_SETTLE);
        stim_out_d   = stim_valid_d ? lfsr_d[4:0] : 5'b00000;
        busy_d       = stim_valid_d || (state_d == S_CAPTURE);
        done_d       = (state_d == S_DONE);
    end

    // State and output registers, with synchronous reset overriding all requests.
    always_ff @(posedge I1470_clk) begin
        if (I1477_rst) begin
            state_q      <= S_IDLE;
            lfsr_q       <= RESET_LFSR;
            misr_q       <= 16'h0000;
            pat_cnt_q    <= 16'h0000;
            settle_cnt_q <= 4'd0;
            stim_out_q   <= 5'b00000;
            stim_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            misr_q       <= misr_d;
            pat_cnt_q    <= pat_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            stim_out_q   <= stim_out_d;
            stim_valid_q <= stim_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign stim_out    = stim_out_q;
    assign stim_valid  = stim_valid_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign signature   = misr_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_stim_pattern_driver.sv
// Bench for stim_pattern_driver. The main instance uses a short run
// (8 patterns, 3 settle cycles). A second instance with a single pattern and
// 2 settle cycles reproduces the exact cycle timeline.
module tb_stim_pattern_driver;

    localparam int          NP   = 8;
    localparam int          ST   = 3;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        seed_load = 1'b0;
    logic [15:0] seed_in = 16'h0000;
    logic        dut_resp = 1'b0;

    logic [4:0]  stim_out, u1_stim_out;
    logic        stim_valid, u1_stim_valid;
    logic        busy, u1_busy;
    logic        done, u1_done;
    logic [15:0] signature, u1_signature;
    logic [2:0]  dbg_state, u1_dbg_state;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] m_lfsr;

    stim_pattern_driver #(.NUM_PATTERNS(NP), .SETTLE_CYCLES(ST), .SEED(SEED)) dut (
        .I1470_clk(clk), .I1477_rst(rst), .start(start), .seed_load(seed_load),
        .seed_in(seed_in), .dut_resp(dut_resp), .stim_out(stim_out),
        .stim_valid(stim_valid), .busy(busy), .done(done),
        .signature(signature), .dbg_state_o(dbg_state)
    );

    stim_pattern_driver #(.NUM_PATTERNS(1), .SETTLE_CYCLES(2), .SEED(SEED)) u1 (
        .I1470_clk(clk), .I1477_rst(rst), .start(start), .seed_load(seed_load),
        .seed_in(seed_in), .dut_resp(dut_resp), .stim_out(u1_stim_out),
        .stim_valid(u1_stim_valid), .busy(u1_busy), .done(u1_done),
        .signature(u1_signature), .dbg_state_o(u1_dbg_state)
    );

    // Clock generation
    always #5 clk = ~clk;

    // Reference rules: one LFSR step and one MISR step.
    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    endfunction

    function automatic logic [15:0] misr_next(input logic [15:0] m, input logic r);
        return {m[0] ^ m[2] ^ m[3] ^ m[5] ^ r, m[15:1]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        start     = 1'($urandom_range(0, 1));
        seed_load = 1'($urandom_range(0, 1));
        seed_in   = 16'($urandom);
        tick();
        tick();
        rst       = 1'b0;
        start     = 1'b0;
        seed_load = 1'b0;
        m_lfsr    = SEED;
    endtask

    // Full run checked cycle by cycle against the model; optional
    // all-zero response and optional start/seed_load pulse while busy.
    task automatic run_check(input bit zero_resp, input bit disturb, input string name);
        logic [15:0] m_misr;
        logic [7:0]  exp_v, act_v;
        logic        r;
        m_misr = 16'h0000;
        start  = 1'b1;
        tick();
        start     = 1'b0;
        seed_load = 1'b0;
        for (int k = 0; k < NP; k++) begin
            for (int s = 0; s <= ST; s++) begin
                exp_v = {1'b1, 1'b1, 1'b0, m_lfsr[4:0]};
                act_v = {stim_valid, busy, done, stim_out};
                n_cmp++;
                if (act_v !== exp_v) begin
                    n_err++;
                    $display("FAIL %s hold p%0d c%0d: got %h expected %h", name, k, s, act_v, exp_v);
                end
                dut_resp = 1'($urandom_range(0, 1));
                if (disturb && k == 1 && s == 1) begin
                    start     = 1'b1;
                    seed_load = 1'b1;
                    seed_in   = 16'($urandom);
                end else begin
                    start     = 1'b0;
                    seed_load = 1'b0;
                end
                tick();
            end
            start     = 1'b0;
            seed_load = 1'b0;
            exp_v = 8'b0100_0000;
            act_v = {stim_valid, busy, done, stim_out};
            n_cmp++;
            if (act_v !== exp_v) begin
                n_err++;
                $display("FAIL %s capture p%0d: got %h expected %h", name, k, act_v, exp_v);
            end
            r        = zero_resp ? 1'b0 : 1'($urandom_range(0, 1));
            dut_resp = r;
            m_misr   = misr_next(m_misr, r);
            m_lfsr   = lfsr_next(m_lfsr);
            tick();
        end
        for (int h = 0; h < 3; h++) begin
            exp_v = 8'b0010_0000;
            act_v = {stim_valid, busy, done, stim_out};
            n_cmp++;
            if (act_v !== exp_v || signature !== m_misr) begin
                n_err++;
                $display("FAIL %s done h%0d: flags %h sig %h expected flags %h sig %h",
                         name, h, act_v, signature, exp_v, m_misr);
            end
            dut_resp = 1'($urandom_range(0, 1));
            tick();
        end
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if ({stim_out, stim_valid, busy, done, signature, dbg_state} !== 29'd0) begin
                n_err++;
                $display("FAIL reset_outputs: got stim %h v %b b %b d %b sig %h st %0d expected all 0",
                         stim_out, stim_valid, busy, done, signature, dbg_state);
            end
            tick();
        end
    endtask

    task automatic test_lfsr_first();
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++;
        if (stim_out !== 5'b00001) begin
            n_err++;
            $display("FAIL first_stim: got %b expected 00001", stim_out);
        end
        repeat (ST + 2) tick();
        n_cmp++;
        if (stim_out !== 5'b10000) begin
            n_err++;
            $display("FAIL second_stim: got %b expected 10000", stim_out);
        end
    endtask

    task automatic test_single();
        logic [2:0] exp_f, act_f;
        do_reset();
        dut_resp = 1'b1;
        start    = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            exp_f = {c <= 3, c <= 4, c == 5};
            act_f = {u1_stim_valid, u1_busy, u1_done};
            n_cmp++;
            if (act_f !== exp_f) begin
                n_err++;
                $display("FAIL single_timeline c%0d: got %b expected %b", c, act_f, exp_f);
            end
            if (c < 5) tick();
        end
        n_cmp++;
        if (u1_signature !== 16'h8000) begin
            n_err++;
            $display("FAIL single_signature: got %h expected 8000", u1_signature);
        end
    endtask

    task automatic test_seed_zero();
        do_reset();
        seed_load = 1'b1;
        seed_in   = 16'h0000;
        tick();
        seed_load = 1'b0;
        start     = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++;
        if ({stim_valid, stim_out} !== 6'b1_00001) begin
            n_err++;
            $display("FAIL seed_zero: got v %b stim %b expected v 1 stim 00001", stim_valid, stim_out);
        end
    endtask

    task automatic test_seed_with_start();
        logic [15:0] s;
        do_reset();
        s         = 16'($urandom);
        seed_in   = s;
        seed_load = 1'b1;
        m_lfsr    = (s == 16'h0000) ? 16'h0001 : s;
        run_check(1'b0, 1'b0, "seed_and_start");
    endtask

    task automatic test_disturb();
        do_reset();
        run_check(1'b0, 1'b1, "start_during_settle");
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat ((ST + 2) * 2 + ST + 1) tick();
        n_cmp++;
        if ({stim_valid, busy, done} !== 3'b010) begin
            n_err++;
            $display("FAIL abort_in_capture: got %b expected 010", {stim_valid, busy, done});
        end
        rst       = 1'b1;
        start     = 1'b1;
        seed_load = 1'b1;
        seed_in   = 16'($urandom);
        tick();
        n_cmp++;
        if ({stim_out, stim_valid, busy, done, signature, dbg_state} !== 29'd0) begin
            n_err++;
            $display("FAIL abort_outputs: got stim %h v %b b %b d %b sig %h st %0d expected all 0",
                     stim_out, stim_valid, busy, done, signature, dbg_state);
        end
        rst       = 1'b0;
        start     = 1'b0;
        seed_load = 1'b0;
        m_lfsr    = SEED;
        run_check(1'b0, 1'b0, "fresh_after_abort");
    endtask

    task automatic test_back_to_back();
        do_reset();
        run_check(1'b1, 1'b0, "b2b_run1");
        run_check(1'b1, 1'b0, "b2b_run2");
        n_cmp++;
        if (signature !== 16'h0000) begin
            n_err++;
            $display("FAIL b2b_zero_sig: got %h expected 0000", signature);
        end
    endtask

    task automatic test_random_runs();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            run_check(1'b0, 1'b0, "random_run");
        end
    endtask

    initial begin
        test_reset();
        test_lfsr_first();
        test_single();
        test_seed_zero();
        test_seed_with_start();
        test_disturb();
        test_reset_mid_run();
        test_back_to_back();
        test_random_runs();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
